// File: rtl/poets_packet_router.sv
// poets_packet_router
//   Single-input, two-output Avalon-ST packet router placed in front of the
//   NIOS node's stream_in port. The first beat of each packet carries the
//   destination in data[15:0]; packets addressed to NODE_ID go to local_*,
//   everything else goes to fwd_*. Beats that arrive outside a packet are
//   discarded. Three saturating counters expose per-path traffic for debug.
//
// Ports
//   clk_clk, reset_reset          clock, synchronous active-high reset
//   stream_in_*                   upstream Avalon-ST sink (ready is registered)
//   local_* / local_ready         Avalon-ST source towards the local node
//   fwd_*   / fwd_ready           Avalon-ST source towards the next hop
//   local_pkt_count               packets delivered locally (saturating)
//   fwd_pkt_count                 packets forwarded (saturating)
//   drop_count                    discarded beats / abandoned packets (saturating)
//
// FSM
//   state    | meaning
//   ST_IDLE  | between packets; head sop opens a packet, head !sop is dropped
//   ST_LOCAL | inside a packet routed to local_*
//   ST_FWD   | inside a packet routed to fwd_*

module poets_packet_router #(
    parameter logic [15:0] NODE_ID = 16'h0001,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk_clk,
    input  logic             reset_reset,

    input  logic             stream_in_valid,
    input  logic [31:0]      stream_in_data,
    input  logic             stream_in_startofpacket,
    input  logic             stream_in_endofpacket,
    input  logic [1:0]       stream_in_empty,
    output logic             stream_in_ready,

    output logic             local_valid,
    output logic [31:0]      local_data,
    output logic             local_startofpacket,
    output logic             local_endofpacket,
    output logic [1:0]       local_empty,
    input  logic             local_ready,

    output logic             fwd_valid,
    output logic [31:0]      fwd_data,
    output logic             fwd_startofpacket,
    output logic             fwd_endofpacket,
    output logic [1:0]       fwd_empty,
    input  logic             fwd_ready,

    output logic [CNT_W-1:0] local_pkt_count,
    output logic [CNT_W-1:0] fwd_pkt_count,
    output logic [CNT_W-1:0] drop_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCAL = 2'd1,
        ST_FWD   = 2'd2
    } state_t;

    // Buffer entry layout: {sop, eop, empty[1:0], data[31:0]}
    localparam int unsigned BW = 36;

    logic [BW-1:0]    buf0_q, buf0_d;   // head entry, drives both output buses
    logic [BW-1:0]    buf1_q, buf1_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             ready_q, ready_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] lcnt_q, lcnt_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;

    logic             head_valid;
    logic             head_sop;
    logic             head_eop;
    logic [1:0]       head_empty;
    logic [31:0]      head_data;
    logic             route_local;
    logic             drop_beat;
    logic             sel_valid;
    logic             push;
    logic             pop;
    logic [1:0]       cnt_pop;
    logic [BW-1:0]    in_beat;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign head_valid = (cnt_q != 2'd0);
    assign head_sop   = buf0_q[35];
    assign head_eop   = buf0_q[34];
    assign head_empty = buf0_q[33:32];
    assign head_data  = buf0_q[31:0];

    // A header beat picks its route from its own destination field, even
    // mid-packet, so a packet that lost its eop is replaced by the new one.
    assign route_local = head_sop ? (head_data[15:0] == NODE_ID)
                                  : (state_q == ST_LOCAL);
    assign drop_beat   = head_valid && !head_sop && (state_q == ST_IDLE);
    assign sel_valid   = head_valid && !drop_beat;

    assign local_valid = sel_valid &&  route_local;
    assign fwd_valid   = sel_valid && !route_local;

    assign push = stream_in_valid && ready_q;
    assign pop  = drop_beat || (local_valid && local_ready)
                            || (fwd_valid && fwd_ready);

    assign in_beat = {stream_in_startofpacket, stream_in_endofpacket,
                      stream_in_empty, stream_in_data};

    always_comb begin
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        cnt_pop = cnt_q - {1'b0, pop};
        if (pop) begin
            buf0_d = buf1_q;
        end
        if (push) begin
            if (cnt_pop == 2'd0) begin
                buf0_d = in_beat;
            end else begin
                buf1_d = in_beat;
            end
        end
        cnt_d   = cnt_pop + {1'b0, push};
        // ready is a register, so it must already reflect this cycle's
        // push/pop; this keeps the two-entry buffer from ever overflowing.
        ready_d = (cnt_d != 2'd2);
    end

    always_comb begin
        state_d = state_q;
        lcnt_d  = lcnt_q;
        fcnt_d  = fcnt_q;
        dcnt_d  = dcnt_q;
        if (drop_beat) begin
            dcnt_d = sat_inc(dcnt_q);
        end else if (pop) begin
            if (head_sop && (state_q != ST_IDLE)) begin
                dcnt_d = sat_inc(dcnt_q);
            end
            if (head_eop) begin
                state_d = ST_IDLE;
                if (route_local) begin
                    lcnt_d = sat_inc(lcnt_q);
                end else begin
                    fcnt_d = sat_inc(fcnt_q);
                end
            end else begin
                state_d = route_local ? ST_LOCAL : ST_FWD;
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            buf0_q  <= '0;
            buf1_q  <= '0;
            cnt_q   <= 2'd0;
            ready_q <= 1'b0;
            state_q <= ST_IDLE;
            lcnt_q  <= '0;
            fcnt_q  <= '0;
            dcnt_q  <= '0;
        end else begin
            buf0_q  <= buf0_d;
            buf1_q  <= buf1_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            state_q <= state_d;
            lcnt_q  <= lcnt_d;
            fcnt_q  <= fcnt_d;
            dcnt_q  <= dcnt_d;
        end
    end

    assign stream_in_ready     = ready_q;

    assign local_data          = head_data;
    assign local_startofpacket = head_sop;
    assign local_endofpacket   = head_eop;
    assign local_empty         = head_empty;

    assign fwd_data            = head_data;
    assign fwd_startofpacket   = head_sop;
    assign fwd_endofpacket     = head_eop;
    assign fwd_empty           = head_empty;

    assign local_pkt_count     = lcnt_q;
    assign fwd_pkt_count       = fcnt_q;
    assign drop_count          = dcnt_q;

endmodule

// File: tb/tb_poets_packet_router.sv
module tb_poets_packet_router;

    logic        clk_clk = 1'b0;
    logic        reset_reset;
    logic        stream_in_valid;
    logic [31:0] stream_in_data;
    logic        stream_in_startofpacket;
    logic        stream_in_endofpacket;
    logic [1:0]  stream_in_empty;
    logic        stream_in_ready;
    logic        local_valid, local_startofpacket, local_endofpacket, local_ready;
    logic [31:0] local_data;
    logic [1:0]  local_empty;
    logic        fwd_valid, fwd_startofpacket, fwd_endofpacket, fwd_ready;
    logic [31:0] fwd_data;
    logic [1:0]  fwd_empty;
    logic [15:0] local_pkt_count, fwd_pkt_count, drop_count;

    poets_packet_router dut (
        .clk_clk                 (clk_clk),
        .reset_reset             (reset_reset),
        .stream_in_valid         (stream_in_valid),
        .stream_in_data          (stream_in_data),
        .stream_in_startofpacket (stream_in_startofpacket),
        .stream_in_endofpacket   (stream_in_endofpacket),
        .stream_in_empty         (stream_in_empty),
        .stream_in_ready         (stream_in_ready),
        .local_valid             (local_valid),
        .local_data              (local_data),
        .local_startofpacket     (local_startofpacket),
        .local_endofpacket       (local_endofpacket),
        .local_empty             (local_empty),
        .local_ready             (local_ready),
        .fwd_valid               (fwd_valid),
        .fwd_data                (fwd_data),
        .fwd_startofpacket       (fwd_startofpacket),
        .fwd_endofpacket         (fwd_endofpacket),
        .fwd_empty               (fwd_empty),
        .fwd_ready               (fwd_ready),
        .local_pkt_count         (local_pkt_count),
        .fwd_pkt_count           (fwd_pkt_count),
        .drop_count              (drop_count)
    );

    always #5 clk_clk = ~clk_clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // beat record: {sop, eop, empty[1:0], data[31:0]}
    logic [35:0] lq[$], fq[$], exp_l[$], exp_f[$];
    int          lc[$];
    logic        rec_en = 1'b1;
    int          both_viol = 0;
    int          stall_viol = 0;
    logic        prev_lstall = 1'b0;
    logic [35:0] prev_l;

    always @(posedge clk_clk) cyc <= cyc + 1;

    always @(negedge clk_clk) begin
        if (reset_reset) begin
            prev_lstall = 1'b0;
        end else if (rec_en) begin
            if (local_valid && local_ready) begin
                lq.push_back({local_startofpacket, local_endofpacket, local_empty, local_data});
                lc.push_back(cyc);
            end
            if (fwd_valid && fwd_ready)
                fq.push_back({fwd_startofpacket, fwd_endofpacket, fwd_empty, fwd_data});
            if (local_valid && fwd_valid) both_viol++;
            if (prev_lstall && (!local_valid ||
                {local_startofpacket, local_endofpacket, local_empty, local_data} != prev_l))
                stall_viol++;
            prev_lstall = local_valid && !local_ready;
            prev_l      = {local_startofpacket, local_endofpacket, local_empty, local_data};
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    function automatic logic [35:0] mk(input logic sop, input logic eop,
                                       input logic [1:0] emp, input logic [31:0] d);
        return {sop, eop, emp, d};
    endfunction

    task automatic send_beat(input logic [35:0] b);
        logic acc;
        logic ok;
        stream_in_valid         = 1'b1;
        stream_in_startofpacket = b[35];
        stream_in_endofpacket   = b[34];
        stream_in_empty         = b[33:32];
        stream_in_data          = b[31:0];
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            acc = stream_in_ready;
            tick();
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_val("send_timeout", 0, 1);
    endtask

    task automatic idle_in();
        stream_in_valid         = 1'b0;
        stream_in_startofpacket = 1'b0;
        stream_in_endofpacket   = 1'b0;
        stream_in_empty         = 2'd0;
        stream_in_data          = 32'h0;
    endtask

    task automatic do_reset();
        idle_in();
        local_ready = 1'b1;
        fwd_ready   = 1'b1;
        reset_reset = 1'b1;
        tick();
        tick();
        reset_reset = 1'b0;
        tick();
        lq.delete(); fq.delete(); lc.delete();
        exp_l.delete(); exp_f.delete();
        both_viol  = 0;
        stall_viol = 0;
    endtask

    task automatic check_streams(input string tag);
        check_val({tag, "_lsize"}, lq.size(), exp_l.size());
        check_val({tag, "_fsize"}, fq.size(), exp_f.size());
        for (int i = 0; i < exp_l.size() && i < lq.size(); i++)
            check_val({tag, "_lbeat"}, lq[i], exp_l[i]);
        for (int i = 0; i < exp_f.size() && i < fq.size(); i++)
            check_val({tag, "_fbeat"}, fq[i], exp_f[i]);
        check_val({tag, "_both_valid"}, both_viol, 0);
    endtask

    initial begin
        int n;
        int budget;
        logic acc;
        logic [35:0] pkt[$];

        idle_in();
        local_ready = 1'b1;
        fwd_ready   = 1'b1;
        reset_reset = 1'b1;
        tick();
        tick();
        check_val("rst_in_ready", stream_in_ready, 0);
        check_val("rst_local_valid", local_valid, 0);
        check_val("rst_fwd_valid", fwd_valid, 0);
        check_val("rst_counts", {local_pkt_count, fwd_pkt_count, drop_count}, 0);
        check_val("rst_data", {local_data, fwd_data, local_empty, local_startofpacket, local_endofpacket}, 0);
        reset_reset = 1'b0;
        tick();
        check_val("rst_release_ready", stream_in_ready, 1);

        // 1: local 3-beat packet, one-cycle latency, back-to-back
        do_reset();
        pkt = '{mk(1,0,0,32'h0000_0001), mk(0,0,0,32'hA5A5_0000), mk(0,1,2,32'h1234_5678)};
        exp_l = pkt;
        send_beat(pkt[0]);
        check_val("t1_lat_valid", local_valid, 1);
        check_val("t1_lat_data", local_data, 32'h0000_0001);
        check_val("t1_lat_fwd_valid", fwd_valid, 0);
        send_beat(pkt[1]);
        send_beat(pkt[2]);
        idle_in();
        repeat (4) tick();
        check_streams("t1");
        if (lc.size() == 3) begin
            check_val("t1_b2b_1", lc[1] - lc[0], 1);
            check_val("t1_b2b_2", lc[2] - lc[1], 1);
        end
        check_val("t1_local_cnt", local_pkt_count, 1);
        check_val("t1_fwd_cnt", fwd_pkt_count, 0);

        // 2: forwarded 4-beat packet
        do_reset();
        pkt = '{mk(1,0,0,32'hABCD_0007), mk(0,0,0,32'h1111_1111),
                mk(0,0,0,32'h2222_2222), mk(0,1,1,32'h3333_3333)};
        exp_f = pkt;
        foreach (pkt[i]) send_beat(pkt[i]);
        idle_in();
        repeat (4) tick();
        check_streams("t2");
        check_val("t2_fwd_cnt", fwd_pkt_count, 1);
        check_val("t2_local_cnt", local_pkt_count, 0);

        // 3: backpressure on local path
        do_reset();
        pkt = '{mk(1,0,0,32'h5555_0001), mk(0,0,0,32'hC0DE_0001), mk(0,0,0,32'hC0DE_0002),
                mk(0,0,0,32'hC0DE_0003), mk(0,0,0,32'hC0DE_0004), mk(0,1,3,32'hC0DE_0005)};
        exp_l = pkt;
        local_ready = 1'b0;
        fork
            begin
                foreach (pkt[i]) send_beat(pkt[i]);
                idle_in();
            end
            begin
                tick();
                check_val("t3_ready_one_entry", stream_in_ready, 1);
                tick();
                check_val("t3_ready_full", stream_in_ready, 0);
                tick();
                tick();
                check_val("t3_ready_still_full", stream_in_ready, 0);
                check_val("t3_no_out_while_stalled", lq.size(), 0);
                for (int i = 0; i < 45; i++) begin
                    local_ready = (i % 3 == 0);
                    tick();
                end
                local_ready = 1'b1;
            end
        join
        repeat (4) tick();
        check_streams("t3");
        check_val("t3_stall_stable", stall_viol, 0);
        check_val("t3_local_cnt", local_pkt_count, 1);

        // 4: stray non-sop beat then single-beat local packet
        do_reset();
        send_beat(mk(0,0,0,32'hDEAD_0001));
        send_beat(mk(1,1,0,32'h0000_0001));
        exp_l.push_back(mk(1,1,0,32'h0000_0001));
        idle_in();
        repeat (4) tick();
        check_streams("t4");
        check_val("t4_drop_cnt", drop_count, 1);
        check_val("t4_local_cnt", local_pkt_count, 1);

        // 5: packet A loses its eop, packet B takes over
        do_reset();
        pkt = '{mk(1,0,0,32'h0000_0001), mk(0,0,0,32'hAAAA_AAAA),
                mk(1,0,0,32'h0000_0007), mk(0,1,0,32'hBBBB_BBBB)};
        exp_l = '{pkt[0], pkt[1]};
        exp_f = '{pkt[2], pkt[3]};
        foreach (pkt[i]) send_beat(pkt[i]);
        idle_in();
        repeat (4) tick();
        check_streams("t5");
        check_val("t5_drop_cnt", drop_count, 1);
        check_val("t5_fwd_cnt", fwd_pkt_count, 1);
        check_val("t5_local_cnt", local_pkt_count, 0);

        // 6: reset mid-packet
        do_reset();
        send_beat(mk(1,1,0,32'h0000_0001));
        idle_in();
        repeat (3) tick();
        check_val("t6_pre_local_cnt", local_pkt_count, 1);
        local_ready = 1'b0;
        send_beat(mk(1,0,0,32'h0000_0001));
        send_beat(mk(0,0,0,32'h7777_7777));
        idle_in();
        check_val("t6_pre_valid", local_valid, 1);
        reset_reset = 1'b1;
        tick();
        check_val("t6_rst_local_valid", local_valid, 0);
        check_val("t6_rst_fwd_valid", fwd_valid, 0);
        check_val("t6_rst_counts", {local_pkt_count, fwd_pkt_count, drop_count}, 0);
        check_val("t6_rst_ready", stream_in_ready, 0);
        reset_reset = 1'b0;
        local_ready = 1'b1;
        tick();
        check_val("t6_release_ready", stream_in_ready, 1);
        check_val("t6_release_valid", local_valid, 0);
        lq.delete(); fq.delete(); exp_l.delete(); exp_f.delete();
        send_beat(mk(1,1,0,32'h0000_0001));
        exp_l.push_back(mk(1,1,0,32'h0000_0001));
        idle_in();
        repeat (3) tick();
        check_streams("t6");
        check_val("t6_local_cnt", local_pkt_count, 1);

        // 7: fwd counter saturation with 2^16+3 single-beat packets
        do_reset();
        rec_en = 1'b0;
        stream_in_valid         = 1'b1;
        stream_in_startofpacket = 1'b1;
        stream_in_endofpacket   = 1'b1;
        stream_in_empty         = 2'd0;
        stream_in_data          = 32'h0000_0007;
        n = 0;
        budget = 0;
        while (n < 65539 && budget < 70000) begin
            acc = stream_in_ready;
            tick();
            if (acc) n++;
            budget++;
        end
        idle_in();
        check_val("t7_sent_all", n, 65539);
        repeat (5) tick();
        check_val("t7_fwd_sat", fwd_pkt_count, 16'hFFFF);
        check_val("t7_local_cnt", local_pkt_count, 0);
        check_val("t7_drop_cnt", drop_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/poets_packet_router.md
Name: poets_packet_router

Overview:
- Single-input, two-output Avalon-ST packet router that sits directly upstream of the NIOS node's stream_in port.
- Accepts 32-bit packets from the inter-node link and decodes the destination field of the first beat.
- Steers each whole packet either to the local node (local_*) or onward to the next hop (fwd_*).
- Drops malformed traffic and keeps per-path packet counters for debug.

Parameters:
- NODE_ID, 16'h0001, destination address that this node answers to.
- CNT_W, 16, width of the saturating status counters.

Ports:
- clk_clk  input  1  system clock; all logic on rising edge
- reset_reset  input  1  synchronous, active-high reset
- stream_in_valid  input  1  upstream beat valid
- stream_in_data  input  32  upstream beat data
- stream_in_startofpacket  input  1  first beat of packet
- stream_in_endofpacket  input  1  last beat of packet
- stream_in_empty  input  2  unused bytes in last beat
- stream_in_ready  output  1  router can accept a beat; registered
- local_valid/local_data[31:0]/local_startofpacket/local_endofpacket/local_empty[1:0]  output  1/32/1/1/2  stream to local node
- local_ready  input  1  local node accepts beat
- fwd_valid/fwd_data[31:0]/fwd_startofpacket/fwd_endofpacket/fwd_empty[1:0]  output  1/32/1/1/2  stream to next hop
- fwd_ready  input  1  next hop accepts beat
- local_pkt_count  output  CNT_W  packets delivered locally, saturating
- fwd_pkt_count  output  CNT_W  packets forwarded, saturating
- drop_count  output  CNT_W  beats discarded, saturating

Behaviour:
- Reset values:
  - All *_valid = 0; stream_in_ready = 0 during reset and 1 the cycle after reset deasserts.
  - Counters = 0; FSM = IDLE; skid buffer empty.
  - Data, sop, eop and empty outputs = 0.
- Input stage: 2-entry skid buffer.
  - A beat is accepted when stream_in_valid && stream_in_ready.
  - stream_in_ready = registered (buffer occupancy < 2 after this cycle's push/pop).
  - Sustained throughput is 1 beat/cycle with both handshakes high.
- Latency: an accepted beat appears on the selected output no earlier than the next cycle, i.e. at least 1 cycle.
- Output path: the head of the skid buffer drives both output data buses.
  - Only the selected path's valid is asserted.
  - Head pops when selected_valid && selected_ready, or when in DROP.
  - The unselected path's ready is ignored.
- Header decode: on a head beat with sop=1, dest = data[15:0].
  - dest == NODE_ID routes local; any other dest routes fwd.
  - The decision is latched for the rest of the packet.
- FSM states and transitions:
  - IDLE: head valid & sop goes to LOCAL or FWD per dest.
  - IDLE: head valid & !sop goes to DROP-beat (the beat is popped and drop_count increments; stay in IDLE).
  - LOCAL/FWD: pop of a beat with eop returns to IDLE, and the matching pkt counter increments by 1.
  - LOCAL/FWD: a beat with sop=1 arriving mid-packet (missing eop) is routed as a new header. The old packet is abandoned without an eop, drop_count increments, and the route is re-latched from the new header.
- Single-beat packet (sop=1, eop=1): routed in one cycle; FSM returns to IDLE in the same pop; counter increments.
- empty is passed through unchanged and is meaningful only when eop=1.
- Counters saturate at all-ones (no wrap). Local and fwd counter increments in one cycle are impossible because there is only one pop per cycle.
- Backpressure:
  - Output signals hold stable while valid && !ready.
  - The skid buffer fills and stream_in_ready drops within 1 cycle.
  - No beat is lost or duplicated.
- Reset mid-packet: buffer and FSM are cleared immediately. A partial packet on the outputs is truncated (no eop emitted); the next accepted beat must be a sop.

Test Plan:
- NODE_ID=1: 3-beat packet, hdr 32'h0000_0001, 32'hA5A5_0000, 32'h1234_5678 with eop, empty=2, both readies=1 -> beats appear on local_* one cycle later, back-to-back; fwd_valid stays 0; local_pkt_count=1; empty=2 on last beat only.
- 4-beat packet with hdr dest 16'h0007 -> all beats on fwd_* only; fwd_pkt_count=1; local_pkt_count unchanged.
- Streaming local packet with local_ready toggled 1,0,0,1,... -> no loss or reorder; outputs stable while stalled; stream_in_ready deasserts within 1 cycle of the buffer filling.
- Beat with sop=0 in IDLE, then a valid 1-beat packet (sop=eop=1, dest=1) -> drop_count=1, local_pkt_count=1.
- Packet A (dest 1) missing eop, followed by packet B sop (dest 7) with eop -> drop_count=1; B fully on fwd; fwd_pkt_count=1.
- Assert reset_reset for 1 cycle mid-packet -> all valids 0 and counters 0 on the next cycle; stream_in_ready=1 one cycle after reset release.
- Force 2^16+3 forwarded packets (CNT_W=16) -> fwd_pkt_count holds 16'hFFFF.
